// File: rtl/ram_param_dp.sv
// rtl/ram_param_dp.sv - parameterised dual-port RAM with clear engine; RAM_PARAM_DP_REGOUT_EN selects registered read outputs
module ram_param_dp #(
    parameter int                DATA_W = 10,
    parameter int                ADDR_W = 10,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

    logic [0:0]        state;
    logic [ADDR_W:0]   cnt;
    logic              done_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic fill_we;
    logic port_we;

    assign busy = (state == CLEAR);
    assign done = done_q;

    // The fill owns the array while busy; clr on the same cycle drops a port A write.
    assign fill_we = busy && !rst;
    assign port_we = !busy && !rst && we && !clr;

    // Clear engine: reset parks in CLEAR so every reset ends with a full fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
            endcase
        end
    end

    // Array write port: fill word during a clear, otherwise port A write.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[cnt[ADDR_W-1:0]] <= FILL;
        end else if (port_we) begin
            mem[addr_a] <= wdata;
        end
    end

`ifdef RAM_PARAM_DP_REGOUT_EN
    logic [DATA_W-1:0] rdata_a_q;
    logic [DATA_W-1:0] rdata_b_q;

    // Registered reads sample the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (rst || busy) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= mem[addr_a];
            rdata_b_q <= mem[addr_b];
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
`else
    assign rdata_a = busy ? '0 : mem[addr_a];
    assign rdata_b = busy ? '0 : mem[addr_b];
`endif

endmodule

// File: doc/ram_param_dp.md
RAM_PARAM_DP -- requirements
Module: ram_param_dp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 10, word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 10, address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter FILL, default 0, DATA_W-bit value written by the clear engine.
REQ-004 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  reset, synchronous and active-high.
REQ-006 Port: we  in  1  write enable for port A.
REQ-007 Port: clr  in  1  clear request; one-cycle pulse restarts the fill of the whole array.
REQ-008 Port: addr_a  in  ADDR_W  port A read/write address.
REQ-009 Port: wdata  in  DATA_W  port A write data.
REQ-010 Port: rdata_a  out  DATA_W  port A read data.
REQ-011 Port: addr_b  in  ADDR_W  port B read-only address.
REQ-012 Port: rdata_b  out  DATA_W  port B read data.
REQ-013 Port: busy  out  1  high while the clear engine owns the array.
REQ-014 Port: done  out  1  one-cycle pulse when a clear completes.

Function
REQ-015 Storage SHALL be DEPTH x DATA_W; every ADDR_W address is valid, with no out-of-range case.
REQ-016 The clear engine SHALL have two states, IDLE and CLEAR, plus a counter cnt of ADDR_W+1 bits.
REQ-017 In CLEAR with rst low, each cycle SHALL write FILL to mem[cnt] and increment cnt.
REQ-018 When the write to address DEPTH-1 occurs, the next state SHALL be IDLE, cnt SHALL be 0, and done SHALL be high for exactly that next cycle.
REQ-019 busy SHALL equal (state == CLEAR); after rst deasserts, busy SHALL stay high for exactly DEPTH cycles.
REQ-020 clr high in IDLE SHALL enter CLEAR with cnt = 0 on the next edge; clr while in CLEAR SHALL be ignored.
REQ-021 A port A write SHALL occur on the rising edge only when we = 1, busy = 0 and clr = 0; clr wins over we on the same cycle and the write is dropped.
REQ-022 we while busy SHALL be discarded silently, with no queueing.
REQ-023 While busy = 1, rdata_a and rdata_b SHALL read as 0 regardless of address.
REQ-024 With the macro undefined, reads SHALL be combinational: rdata_x = mem[addr_x] with zero latency, and the new data SHALL be visible after the write edge.
REQ-025 Both ports reading the same address SHALL return identical data.

Reset
REQ-026 While rst = 1, the state SHALL be CLEAR, cnt SHALL be 0, no array write SHALL occur, busy SHALL be 1 and done SHALL be 0.
REQ-027 rst asserted mid-clear SHALL restart the fill from address 0 after deassertion.
REQ-028 rst asserted in IDLE SHALL also start a full clear; memory contents are not preserved.
REQ-029 Array contents SHALL be undefined before the first completed clear, and the registered read outputs SHALL be 0 on reset.

Configuration
REQ-030 Macro RAM_PARAM_DP_REGOUT_EN SHALL select the read-path type.
REQ-031 With RAM_PARAM_DP_REGOUT_EN defined, rdata_a and rdata_b SHALL be registered with 1-cycle latency and read-first behaviour: a same-address write returns the old word, and the outputs SHALL be 0 on rst or while busy.
REQ-032 With RAM_PARAM_DP_REGOUT_EN undefined, reads SHALL be asynchronous per REQ-024; the write path and clear engine SHALL be identical in both builds.

Verification (ADDR_W=4, DATA_W=10, FILL=0 unless stated)
REQ-033 Bench: rst high 2 cycles, then low -> busy high exactly 16 cycles, done pulses once, all 16 addresses read 0x000.
REQ-034 Bench: IDLE, write 0x241 to addr_a=3, addr_b=3 -> rdata_b = 0x241 immediately after the edge (async build).
REQ-035 Bench: during clear, we=1 to addr 5 with 0x3FF -> after done, addr 5 reads 0x000.
REQ-036 Bench: IDLE, clr=1 and we=1 to addr 2 with 0x155 in the same cycle -> write dropped, busy 16 cycles, addr 2 reads 0x000.
REQ-037 Bench: rst pulsed when cnt=7 -> fill restarts at 0, busy 16 cycles after deassertion, a single done pulse.
REQ-038 Bench (REGOUT_EN defined, FILL=0x2AA): write 0x155 to addr 9; next cycle read addr 9 while writing 0x0AA -> rdata_a = 0x155 one cycle later, then 0x0AA.
